pe_array_sequencer: RTL and testbench

PE_ARRAY_SEQUENCER -- requirements
Module: pe_array_sequencer

---
 rtl/pe_array_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_pe_array_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer
//
// Sequences one pass of a systolic PE array for a query segment of s_len
// PEs against a database of t_len symbols. It walks a diagonal wavefront
// (adv), drives the registered per-PE enables and the t-symbol request,
// captures the boundary column leaving PE s_len-1, and tracks the best V
// score with a two-stage max pipeline.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   i_start            : begin a pass (sampled only in IDLE)
//   i_s_len, i_t_len   : pass lengths, latched on an accepted start
//   i_lock             : stall; no advance while high in RUN
//   o_t_req            : PE0 consumes a new t symbol this cycle
//   o_pe_enable        : registered per-PE enable
//   i_pe_t/v/f         : per-PE t symbol, V and F outputs (PE k at slice k)
//   o_bnd_t/v/f        : boundary word from PE s_len-1
//   o_bnd_valid        : one-cycle pulse per boundary word
//   o_score/row/col    : running best V, its PE index and t index
//   o_done             : one-cycle pulse, results valid
//   o_busy             : high outside IDLE
//   o_dbg_state        : FSM state (IDLE=0, RUN=1, FLUSH=2, DONE=3)
//
// Handshake: there is no backpressure on outputs. i_lock is the only flow
// control; a RUN cycle with i_lock=0 is an advance, and every capture,
// request and counter update happens only on advances.
module pe_array_sequencer #(
  parameter int PE_NUM  = 16,
  parameter int PE_LOG  = 4,
  parameter int SCORE_W = 12,
  parameter int LEN_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [PE_LOG:0]           i_s_len,
  input  logic [LEN_W-1:0]          i_t_len,
  input  logic                      i_lock,
  output logic                      o_t_req,
  output logic [PE_NUM-1:0]         o_pe_enable,
  input  logic [2*PE_NUM-1:0]       i_pe_t,
  input  logic [SCORE_W*PE_NUM-1:0] i_pe_v,
  input  logic [SCORE_W*PE_NUM-1:0] i_pe_f,
  output logic [1:0]                o_bnd_t,
  output logic [SCORE_W-1:0]        o_bnd_v,
  output logic [SCORE_W-1:0]        o_bnd_f,
  output logic                      o_bnd_valid,
  output logic [SCORE_W-1:0]        o_score,
  output logic [PE_LOG-1:0]         o_row,
  output logic [LEN_W-1:0]          o_col,
  output logic                      o_done,
  output logic                      o_busy,
  output logic [1:0]                o_dbg_state
);

  // adv reaches t_len+s_len-2, which needs one bit more than LEN_W.
  localparam int ADV_W = LEN_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADV_W-1:0]    adv_q, adv_d;
  logic [PE_LOG:0]     s_len_q, s_len_d;
  logic [LEN_W-1:0]    t_len_q, t_len_d;
  logic [PE_NUM-1:0]   en_q, en_d;
  logic                clr_best;

  logic                adv_en;
  logic [ADV_W-1:0]    last_adv;

  // Boundary capture
  logic [PE_LOG:0]     s_m1;
  logic [PE_LOG-1:0]   bnd_idx;
  logic                bnd_cap;
  logic [1:0]          bnd_t_q;
  logic [SCORE_W-1:0]  bnd_v_q, bnd_f_q;
  logic                bnd_valid_q;

  // Max pipeline
  logic [SCORE_W-1:0]  cand_v;
  logic [PE_LOG-1:0]   cand_k;
  logic                cand_found;
  logic                s1_valid_q, s1_valid_d;
  logic [SCORE_W-1:0]  s1_v_q;
  logic [PE_LOG-1:0]   s1_k_q;
  logic [ADV_W-1:0]    s1_n_q;
  logic                s2_go;
  logic [SCORE_W-1:0]  best_q;
  logic [PE_LOG-1:0]   row_q;
  logic [LEN_W-1:0]    col_q;

  // Enable pattern for a given state/wavefront position: PE k works on
  // t index adv-k, which must lie inside the database.
  function automatic logic [PE_NUM-1:0] calc_en(input state_e st,
                                                input logic [ADV_W-1:0] adv,
                                                input logic [PE_LOG:0] s,
                                                input logic [LEN_W-1:0] t);
    logic [PE_NUM-1:0] en;
    en = '0;
    if (st == S_RUN) begin
      for (int k = 0; k < PE_NUM; k++) begin
        if ((k < int'(s)) && (adv >= ADV_W'(k)) &&
            ((adv - ADV_W'(k)) < ADV_W'(t))) begin
          en[k] = 1'b1;
        end
      end
    end
    return en;
  endfunction

  assign adv_en   = (state_q == S_RUN) && !i_lock;
  assign last_adv = ADV_W'(t_len_q) + ADV_W'(s_len_q) - ADV_W'(2);

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d  = state_q;
    adv_d    = adv_q;
    s_len_d  = s_len_q;
    t_len_d  = t_len_q;
    clr_best = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          clr_best = 1'b1;
          adv_d    = '0;
          s_len_d  = i_s_len;
          t_len_d  = i_t_len;
          if ((i_s_len == '0) || (i_t_len == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (adv_en) begin
          adv_d = adv_q + ADV_W'(1);
          if (adv_q == last_adv) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Registered enables are computed from the next-state values so that
    // o_pe_enable always matches the current state/adv.
    en_d = calc_en(state_d, adv_d, s_len_d, t_len_d);
  end

  // ---------------- Boundary ----------------
  assign s_m1    = s_len_q - (PE_LOG+1)'(1);
  assign bnd_idx = s_m1[PE_LOG-1:0];
  assign bnd_cap = adv_en && en_q[bnd_idx];

  // ---------------- Max stage 1 (per-advance reduction) ----------------
  // Ascending scan with strict compare so the lowest PE wins ties.
  always_comb begin
    cand_v     = '0;
    cand_k     = '0;
    cand_found = 1'b0;
    for (int k = 0; k < PE_NUM; k++) begin
      if (en_q[k] && (!cand_found || (i_pe_v[k*SCORE_W +: SCORE_W] > cand_v))) begin
        cand_v     = i_pe_v[k*SCORE_W +: SCORE_W];
        cand_k     = PE_LOG'(k);
        cand_found = 1'b1;
      end
    end
  end

  // Stage-1 valid is held while locked in RUN so the pending candidate is
  // neither lost nor consumed twice.
  always_comb begin
    s1_valid_d = 1'b0;
    if (adv_en) begin
      s1_valid_d = 1'b1;
    end else if ((state_q == S_RUN) && i_lock) begin
      s1_valid_d = s1_valid_q;
    end
  end

  assign s2_go = s1_valid_q && !((state_q == S_RUN) && i_lock);

  // ---------------- Registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      adv_q       <= '0;
      s_len_q     <= '0;
      t_len_q     <= '0;
      en_q        <= '0;
      bnd_t_q     <= '0;
      bnd_v_q     <= '0;
      bnd_f_q     <= '0;
      bnd_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_v_q      <= '0;
      s1_k_q      <= '0;
      s1_n_q      <= '0;
      best_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      state_q     <= state_d;
      adv_q       <= adv_d;
      s_len_q     <= s_len_d;
      t_len_q     <= t_len_d;
      en_q        <= en_d;
      bnd_valid_q <= bnd_cap;
      if (bnd_cap) begin
        bnd_t_q <= i_pe_t[2*bnd_idx +: 2];
        bnd_v_q <= i_pe_v[SCORE_W*bnd_idx +: SCORE_W];
        bnd_f_q <= i_pe_f[SCORE_W*bnd_idx +: SCORE_W];
      end
      s1_valid_q <= s1_valid_d;
      if (adv_en) begin
        s1_v_q <= cand_v;
        s1_k_q <= cand_k;
        s1_n_q <= adv_q;
      end
      if (clr_best) begin
        best_q <= '0;
        row_q  <= '0;
        col_q  <= '0;
      end else if (s2_go && (s1_v_q > best_q)) begin
        best_q <= s1_v_q;
        row_q  <= s1_k_q;
        col_q  <= LEN_W'(s1_n_q - ADV_W'(s1_k_q));
      end
    end
  end

  // ---------------- Outputs ----------------
  assign o_t_req     = adv_en && (adv_q < ADV_W'(t_len_q));
  assign o_pe_enable = en_q;
  assign o_bnd_t     = bnd_t_q;
  assign o_bnd_v     = bnd_v_q;
  assign o_bnd_f     = bnd_f_q;
  assign o_bnd_valid = bnd_valid_q;
  assign o_score     = best_q;
  assign o_row       = row_q;
  assign o_col       = col_q;
  assign o_done      = (state_q == S_DONE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb_pe_array_sequencer
//
// Directed and randomized passes against a wavefront-level reference model:
// enables, requests, boundary words and the best-score triple are derived
// from the pass geometry and the driven PE values.
module tb_pe_array_sequencer;

  localparam int PE_NUM  = 16;
  localparam int PE_LOG  = 4;
  localparam int SCORE_W = 12;
  localparam int LEN_W   = 12;
  localparam int BW      = 2 + 2*SCORE_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                      i_start = 1'b0;
  logic [PE_LOG:0]           i_s_len = '0;
  logic [LEN_W-1:0]          i_t_len = '0;
  logic                      i_lock  = 1'b0;
  logic [2*PE_NUM-1:0]       i_pe_t  = '0;
  logic [SCORE_W*PE_NUM-1:0] i_pe_v  = '0;
  logic [SCORE_W*PE_NUM-1:0] i_pe_f  = '0;
  logic                      o_t_req;
  logic [PE_NUM-1:0]         o_pe_enable;
  logic [1:0]                o_bnd_t;
  logic [SCORE_W-1:0]        o_bnd_v, o_bnd_f;
  logic                      o_bnd_valid;
  logic [SCORE_W-1:0]        o_score;
  logic [PE_LOG-1:0]         o_row;
  logic [LEN_W-1:0]          o_col;
  logic                      o_done, o_busy;
  logic [1:0]                o_dbg_state;

  pe_array_sequencer #(
    .PE_NUM(PE_NUM), .PE_LOG(PE_LOG), .SCORE_W(SCORE_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_s_len(i_s_len),
    .i_t_len(i_t_len), .i_lock(i_lock), .o_t_req(o_t_req),
    .o_pe_enable(o_pe_enable), .i_pe_t(i_pe_t), .i_pe_v(i_pe_v),
    .i_pe_f(i_pe_f), .o_bnd_t(o_bnd_t), .o_bnd_v(o_bnd_v),
    .o_bnd_f(o_bnd_f), .o_bnd_valid(o_bnd_valid), .o_score(o_score),
    .o_row(o_row), .o_col(o_col), .o_done(o_done), .o_busy(o_busy),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  int m_s, m_t, m_adv;
  int m_best, m_row, m_col;
  int bnd_cnt, treq_cnt;
  int vmax = 63;
  int cur_t[PE_NUM];
  int cur_v[PE_NUM];
  int cur_f[PE_NUM];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // PE k is active at wavefront position a iff it holds a real query row and
  // its t index a-k lies inside the database.
  function automatic logic [PE_NUM-1:0] exp_en(input int a);
    logic [PE_NUM-1:0] e;
    e = '0;
    for (int k = 0; k < PE_NUM; k++)
      if (k < m_s && a - k >= 0 && a - k < m_t) e[k] = 1'b1;
    return e;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_pe(input int a, input int mode);
    for (int k = 0; k < PE_NUM; k++) begin
      cur_t[k] = $urandom_range(0, 3);
      cur_f[k] = $urandom_range(0, 4095);
      if (mode == 1)
        cur_v[k] = ((k == 2 && a == 5) || (k == 1 && a == 7)) ? 37 : $urandom_range(0, 30);
      else
        cur_v[k] = $urandom_range(0, vmax);
      i_pe_t[2*k +: 2]             = cur_t[k][1:0];
      i_pe_v[SCORE_W*k +: SCORE_W] = cur_v[k][SCORE_W-1:0];
      i_pe_f[SCORE_W*k +: SCORE_W] = cur_f[k][SCORE_W-1:0];
    end
  endtask

  task automatic check_bnd();
    logic [BW-1:0] e;
    chk("bnd_valid", {63'd0, o_bnd_valid}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("bnd_word", {38'd0, o_bnd_t, o_bnd_v, o_bnd_f}, {38'd0, e});
    end
    if (o_bnd_valid) bnd_cnt++;
  endtask

  task automatic start_pass(input int s, input int t);
    @(negedge clk);
    i_start = 1'b1;
    i_s_len = s[PE_LOG:0];
    i_t_len = t[LEN_W-1:0];
    i_lock  = 1'b0;
    @(posedge clk);
    m_s = s; m_t = t; m_adv = 0;
    m_best = 0; m_row = 0; m_col = 0;
    bnd_cnt = 0; treq_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // One RUN cycle; entered and left at a negative edge.
  task automatic run_step(input bit lk, input int mode);
    logic [PE_NUM-1:0] e;
    i_lock  = lk;
    i_start = 1'($urandom_range(0, 1));
    i_s_len = 5'($urandom);
    i_t_len = 12'($urandom);
    drive_pe(m_adv, mode);
    e = exp_en(m_adv);
    #1;
    chk("busy_run", {63'd0, o_busy}, 64'd1);
    chk("done_run", {63'd0, o_done}, 64'd0);
    chk("enable", {48'd0, o_pe_enable}, {48'd0, e});
    chk("t_req", {63'd0, o_t_req}, {63'd0, (!lk && m_adv < m_t)});
    check_bnd();
    if (o_t_req) treq_cnt++;
    @(posedge clk);
    if (!lk) begin
      if (e[m_s-1])
        exp_q.push_back({cur_t[m_s-1][1:0], cur_v[m_s-1][SCORE_W-1:0], cur_f[m_s-1][SCORE_W-1:0]});
      for (int k = 0; k < PE_NUM; k++)
        if (e[k] && cur_v[k] > m_best) begin
          m_best = cur_v[k]; m_row = k; m_col = m_adv - k;
        end
      m_adv++;
    end
    @(negedge clk);
  endtask

  task automatic run_pass(input int s, input int t, input int mode,
                          input int lock_pct, input int lock_at, input int lock_len);
    int left;
    int guard;
    bit lk;
    left  = lock_len;
    guard = 0;
    start_pass(s, t);
    while (m_adv < s + t - 1 && guard < 5000) begin
      if (m_adv == lock_at && left > 0) begin
        lk = 1'b1; left--;
      end else begin
        lk = ($urandom_range(0, 99) < lock_pct);
      end
      run_step(lk, mode);
      guard++;
    end
    chk("run_bound", {32'd0, guard < 5000}, 64'd1);
    i_lock = 1'b0; i_start = 1'b0;
    // FLUSH
    #1;
    chk("busy_flush", {63'd0, o_busy}, 64'd1);
    chk("done_flush", {63'd0, o_done}, 64'd0);
    chk("en_flush", {48'd0, o_pe_enable}, 64'd0);
    chk("treq_flush", {63'd0, o_t_req}, 64'd0);
    check_bnd();
    @(posedge clk); @(negedge clk);
    // DONE
    #1;
    chk("done", {63'd0, o_done}, 64'd1);
    chk("busy_done", {63'd0, o_busy}, 64'd1);
    chk("en_done", {48'd0, o_pe_enable}, 64'd0);
    check_bnd();
    chk("score", {52'd0, o_score}, 64'(m_best));
    chk("row", {60'd0, o_row}, 64'(m_row));
    chk("col", {52'd0, o_col}, 64'(m_col));
    chk("bnd_count", 64'(bnd_cnt), 64'(t));
    chk("treq_count", 64'(treq_cnt), 64'(t));
    @(posedge clk); @(negedge clk);
    // IDLE: results held
    #1;
    chk("busy_idle", {63'd0, o_busy}, 64'd0);
    chk("done_idle", {63'd0, o_done}, 64'd0);
    chk("score_hold", {52'd0, o_score}, 64'(m_best));
    chk("col_hold", {52'd0, o_col}, 64'(m_col));
  endtask

  task automatic zero_pass(input int s, input int t);
    start_pass(s, t);
    #1;
    chk("z_done", {63'd0, o_done}, 64'd1);
    chk("z_busy", {63'd0, o_busy}, 64'd1);
    chk("z_score", {52'd0, o_score}, 64'd0);
    chk("z_row", {60'd0, o_row}, 64'd0);
    chk("z_col", {52'd0, o_col}, 64'd0);
    chk("z_bnd_valid", {63'd0, o_bnd_valid}, 64'd0);
    chk("z_en", {48'd0, o_pe_enable}, 64'd0);
    @(posedge clk); @(negedge clk);
    #1;
    chk("z_done_idle", {63'd0, o_done}, 64'd0);
    chk("z_busy_idle", {63'd0, o_busy}, 64'd0);
    chk("z_bnd_valid2", {63'd0, o_bnd_valid}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, o_done}, 64'd0);
    chk({tag, "_treq"}, {63'd0, o_t_req}, 64'd0);
    chk({tag, "_en"}, {48'd0, o_pe_enable}, 64'd0);
    chk({tag, "_bnd"}, {37'd0, o_bnd_valid, o_bnd_t, o_bnd_v, o_bnd_f}, 64'd0);
    chk({tag, "_res"}, {36'd0, o_score, o_row, o_col}, 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("reset");

    vmax = 63;
    run_pass(4, 6, 0, 0, -1, 0);          // basic wavefront
    run_pass(16, 3, 0, 0, -1, 0);         // full array, short database
    run_pass(4, 8, 1, 0, -1, 0);          // equal maxima at different advances
    chk("tie_score", {52'd0, o_score}, 64'd37);
    chk("tie_row", {60'd0, o_row}, 64'd2);
    chk("tie_col", {52'd0, o_col}, 64'd3);
    run_pass(4, 6, 0, 0, 3, 4);           // 4-cycle lock mid-run
    zero_pass(5, 0);
    zero_pass(0, 7);
    run_pass(1, 1, 0, 0, -1, 0);          // smallest pass

    // reset mid-pass at adv=3
    start_pass(4, 6);
    for (int i = 0; i < 3; i++) run_step(1'b0, 0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); @(negedge clk);
    #1;
    chk("midrst_no_done", {63'd0, o_done}, 64'd0);
    chk("midrst_no_bnd", {63'd0, o_bnd_valid}, 64'd0);
    run_pass(4, 6, 0, 0, -1, 0);

    // randomized passes
    for (int p = 0; p < 10; p++) begin
      vmax = (p % 2 == 0) ? 15 : 4095;
      run_pass($urandom_range(1, PE_NUM), $urandom_range(1, 20), 0, 25, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
